sw_score_collector: RTL and testbench

Downstream collector for the Smith-Waterman systolic array. Consumes the stream of cell scores leaving the last `SWCell` column, one score per valid cycle. Tracks the running maximum score and the stream index where it first occurred. Presents the final result (max, position, sample count) on a valid/ready output once the last sample arrives.

---
 rtl/sw_score_collector.sv | 117 +++++++++++
 tb/tb_sw_score_collector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_score_collector.sv
// sw_score_collector
//   Collector for the Smith-Waterman systolic array output stream. Keeps the
//   running maximum score and the index where it first appeared. It presents
//   {max, pos, count, ovf} on a valid/ready port after the last sample.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   io_start            begin a new alignment (clears tracking state)
//   io_in_valid/score/last, io_in_ready   sample stream (ready only in RUN)
//   io_out_valid/ready  result handshake (valid only in DONE)
//   io_out_max/pos/count/ovf              registered result
//
// Optional feature
//   SW_COLLECT_PRINTF_EN: simulation-only print of each delivered result.
module sw_score_collector #(
  parameter int SCORE_W = 16,
  parameter int POS_W   = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_start,
  input  logic               io_in_valid,
  input  logic [SCORE_W-1:0] io_in_score,
  input  logic               io_in_last,
  output logic               io_in_ready,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [SCORE_W-1:0] io_out_max,
  output logic [POS_W-1:0]   io_out_pos,
  output logic [POS_W-1:0]   io_out_count,
  output logic               io_out_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [POS_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  logic   clear, accept;

  // Moore handshake outputs: decoded from the state register only.
  assign io_in_ready  = (state == S_RUN);
  assign io_out_valid = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (io_start) begin
          clear     = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // start aborts: any sample in the same cycle is dropped, last included
        if (io_start) begin
          clear = 1'b1;
        end else if (io_in_valid) begin
          accept = 1'b1;
          if (io_in_last) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // start alone is ignored so an undelivered result is never lost
        if (io_out_ready) begin
          if (io_start) begin
            clear     = 1'b1;
            state_nxt = S_RUN;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      io_out_max   <= '0;
      io_out_pos   <= '0;
      io_out_count <= '0;
      io_out_ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        io_out_max   <= '0;
        io_out_pos   <= '0;
        io_out_count <= '0;
        io_out_ovf   <= 1'b0;
      end else if (accept) begin
        // Count never wraps, so count==0 identifies the first sample. Strict
        // '>' keeps the earliest index on ties; pos follows the saturated count.
        if (io_out_count == '0 || io_in_score > io_out_max) begin
          io_out_max <= io_in_score;
          io_out_pos <= io_out_count;
        end
        if (io_out_count != CNT_MAX) io_out_count <= io_out_count + 1'b1;
        else                         io_out_ovf   <= 1'b1;
      end
    end
  end

`ifdef SW_COLLECT_PRINTF_EN
`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset && state == S_DONE && io_out_ready)
      $display("sw_score_collector: max=%0d pos=%0d count=%0d ovf=%0d",
               io_out_max, io_out_pos, io_out_count, io_out_ovf);
  end
`endif
`endif

endmodule

// File: tb/tb_sw_score_collector.sv
module tb_sw_score_collector;

  logic        clock = 1'b0;
  logic        reset, start, in_valid, in_last, out_ready;
  logic [15:0] in_score;
  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_max;
  logic [9:0]  out_pos, out_count;

  // second instance with a 3-bit counter for overflow corners
  logic        o_start, o_in_valid, o_in_last, o_out_ready;
  logic [15:0] o_in_score;
  logic        o_in_ready, o_out_valid, o_out_ovf;
  logic [15:0] o_out_max;
  logic [2:0]  o_out_pos, o_out_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sw_score_collector dut (
    .clock(clock), .reset(reset), .io_start(start), .io_in_valid(in_valid),
    .io_in_score(in_score), .io_in_last(in_last), .io_in_ready(in_ready),
    .io_out_valid(out_valid), .io_out_ready(out_ready), .io_out_max(out_max),
    .io_out_pos(out_pos), .io_out_count(out_count), .io_out_ovf(out_ovf)
  );

  sw_score_collector #(.SCORE_W(16), .POS_W(3)) dut_ovf (
    .clock(clock), .reset(reset), .io_start(o_start), .io_in_valid(o_in_valid),
    .io_in_score(o_in_score), .io_in_last(o_in_last), .io_in_ready(o_in_ready),
    .io_out_valid(o_out_valid), .io_out_ready(o_out_ready), .io_out_max(o_out_max),
    .io_out_pos(o_out_pos), .io_out_count(o_out_count), .io_out_ovf(o_out_ovf)
  );

  typedef struct packed {
    logic [15:0] mx;
    logic [9:0]  pos;
    logic [9:0]  cnt;
    logic        ovf;
  } res_t;

  typedef struct {
    int          n;
    logic [15:0] s0, s1, s2, s3, s4;
    res_t        exp;
  } vec_t;

  res_t exp_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // scoreboard: pop on every completed result handshake of the main instance
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("sb_max", {16'd0, out_max}, {16'd0, e.mx});
        chk("sb_pos", {22'd0, out_pos}, {22'd0, e.pos});
        chk("sb_count", {22'd0, out_count}, {22'd0, e.cnt});
        chk("sb_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
      end
    end
  end

  function automatic logic [15:0] sel(input vec_t v, input int i);
    case (i)
      0: return v.s0;
      1: return v.s1;
      2: return v.s2;
      3: return v.s3;
      default: return v.s4;
    endcase
  endfunction

  // drive one sample; push the expected result when it is the last one
  task automatic sample(input logic [15:0] s, input logic last, input res_t e);
    in_valid = 1'b1; in_score = s; in_last = last;
    if (last) exp_q.push_back(e);
    cyc();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    start = 1'b1; cyc(); start = 1'b0;
    chk("start_in_ready", {31'd0, in_ready}, 32'd1);
    chk("start_count", {22'd0, out_count}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < v.n; i++) sample(sel(v, i), (i == v.n - 1), v.exp);
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("back_to_idle", {30'd0, in_ready, out_valid}, 32'd0);
  endtask

  initial begin
    res_t bp, dummy;
    dummy = '0;
    reset = 1'b1; start = 0; in_valid = 0; in_last = 0; in_score = 0; out_ready = 0;
    o_start = 0; o_in_valid = 0; o_in_last = 0; o_in_score = 0; o_out_ready = 0;

    vecs[0] = '{5, 16'd3, 16'd7, 16'd2, 16'd9, 16'd4, '{16'd9, 10'd3, 10'd5, 1'b0}};
    vecs[1] = '{4, 16'd0, 16'd5, 16'd5, 16'd1, 16'd0, '{16'd5, 10'd1, 10'd4, 1'b0}};
    vecs[2] = '{3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, '{16'd0, 10'd0, 10'd3, 1'b0}};
    vecs[3] = '{1, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, '{16'hFFFF, 10'd0, 10'd1, 1'b0}};
    vecs[4] = '{4, 16'd10, 16'h8000, 16'h7FFF, 16'h8000, 16'd0, '{16'h8000, 10'd1, 10'd4, 1'b0}};

    cyc(); cyc();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", {out_max, out_pos, out_count, out_ovf} , 37'd0);
    reset = 1'b0;
    in_valid = 1'b1; cyc(); cyc(); in_valid = 1'b0;
    chk("idle_ignores_samples", {22'd0, out_count}, 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // backpressure: result must hold and start must be ignored
    bp = '{16'd2, 10'd1, 10'd2, 1'b0};
    out_ready = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    sample(16'd1, 1'b0, dummy);
    sample(16'd2, 1'b1, bp);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3 || i == 4);
      cyc();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_result", {out_max, out_pos, out_count, out_ovf}, {bp.mx, bp.pos, bp.cnt, bp.ovf});
    end
    start = 1'b0; out_ready = 1'b1; cyc();
    chk("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd0);

    // abort with a last-flagged sample, then back-to-back turnaround
    out_ready = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    sample(16'd8, 1'b0, dummy);
    sample(16'd6, 1'b0, dummy);
    start = 1'b1; in_valid = 1'b1; in_score = 16'd20; in_last = 1'b1; cyc();
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("abort_stays_run", {30'd0, in_ready, out_valid}, 32'd2);
    chk("abort_cleared", {22'd0, out_count}, 32'd0);
    sample(16'd4, 1'b0, dummy);
    sample(16'd2, 1'b1, '{16'd4, 10'd0, 10'd2, 1'b0});
    chk("abort_done", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    chk("b2b_run", {30'd0, in_ready, out_valid}, 32'd2);
    chk("b2b_cleared", {out_max, out_pos, out_count, out_ovf}, 37'd0);
    sample(16'd11, 1'b1, '{16'd11, 10'd0, 10'd1, 1'b0});
    cyc();
    chk("b2b_idle", {30'd0, in_ready, out_valid}, 32'd0);

    // overflow on the 3-bit instance: max at index 8
    o_start = 1'b1; cyc(); o_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      o_in_valid = 1'b1; o_in_score = (i == 8) ? 16'd100 : 16'(i);
      o_in_last = (i == 8);
      cyc();
      if (i == 6) begin
        chk("ovf_sat_count", {29'd0, o_out_count}, 32'd7);
        chk("ovf_not_yet", {31'd0, o_out_ovf}, 32'd0);
      end
    end
    o_in_valid = 1'b0; o_in_last = 1'b0;
    chk("ovf_valid", {31'd0, o_out_valid}, 32'd1);
    chk("ovf_max", {16'd0, o_out_max}, 32'd100);
    chk("ovf_count", {29'd0, o_out_count}, 32'd7);
    chk("ovf_flag", {31'd0, o_out_ovf}, 32'd1);
    chk("ovf_pos", {29'd0, o_out_pos}, 32'd7);
    o_out_ready = 1'b1; cyc(); o_out_ready = 1'b0;
    chk("ovf_idle", {31'd0, o_out_valid}, 32'd0);

    // reset mid-run
    out_ready = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    sample(16'd5, 1'b0, dummy);
    sample(16'd9, 1'b0, dummy);
    sample(16'd1, 1'b0, dummy);
    chk("pre_reset_count", {22'd0, out_count}, 32'd3);
    reset = 1'b1; start = 1'b1; cyc(); reset = 1'b0; start = 1'b0;
    chk("rst_handshake", {30'd0, in_ready, out_valid}, 32'd0);
    chk("rst_result", {out_max, out_pos, out_count, out_ovf}, 37'd0);
    in_valid = 1'b1; in_score = 16'd7; cyc(); cyc(); in_valid = 1'b0;
    chk("rst_stays_idle", {31'd0, in_ready}, 32'd0);
    chk("rst_no_accept", {22'd0, out_count}, 32'd0);

    cyc();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
